// File: rtl/gemm_ctrl_if.sv
// Host/RAM/array-side signal bundle for gemm_ctrl.
// The slave view belongs to the sequencer; the master view belongs to its environment.
interface gemm_ctrl_if #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 16
);
    logic                    i_start;
    logic [C_ADDR_WIDTH-1:0] i_len;
    logic [C_ADDR_WIDTH-1:0] i_a_base;
    logic [C_ADDR_WIDTH-1:0] i_b_base;
    logic                    i_pause;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_src_rd_en;
    logic [C_ADDR_WIDTH-1:0] o_a_addr;
    logic [C_ADDR_WIDTH-1:0] o_b_addr;
    logic [C_DATA_WIDTH-1:0] i_a_data;
    logic [C_DATA_WIDTH-1:0] i_b_data;
    logic [C_DATA_WIDTH-1:0] o_ain_data;
    logic [C_DATA_WIDTH-1:0] o_bin_data;
    logic                    o_ain_valid;
    logic                    o_bin_valid;
    logic                    o_rd_output;
    logic                    i_rd_return;

    modport master (
        output i_start, i_len, i_a_base, i_b_base, i_pause,
        output i_a_data, i_b_data, i_rd_return,
        input  o_busy, o_done, o_src_rd_en, o_a_addr, o_b_addr,
        input  o_ain_data, o_bin_data, o_ain_valid, o_bin_valid,
        input  o_rd_output
    );

    modport slave (
        input  i_start, i_len, i_a_base, i_b_base, i_pause,
        input  i_a_data, i_b_data, i_rd_return,
        output o_busy, o_done, o_src_rd_en, o_a_addr, o_b_addr,
        output o_ain_data, o_bin_data, o_ain_valid, o_bin_valid,
        output o_rd_output
    );
endinterface

// File: rtl/gemm_ctrl.sv
// Job sequencer for one gemm_array chain: streams operands,
// waits out the PE pipeline, then issues and tracks the rd_output token.
module gemm_ctrl #(
    parameter int C_DATA_WIDTH    = 32,
    parameter int C_ADDR_WIDTH    = 16,
    parameter int C_NUM_PE        = 4,
    parameter int C_RAM_OUT_DELAY = 1,
    parameter int C_MAC_DELAY     = 1
) (
    input logic       clock,
    input logic       i_reset,
    gemm_ctrl_if.slave bus
);
    localparam int AW = C_ADDR_WIDTH;
    localparam int DW = C_DATA_WIDTH;
    localparam int D  = C_RAM_OUT_DELAY;
    localparam int W  = C_NUM_PE * (C_MAC_DELAY + 1);
    localparam int CW = 16;

    localparam logic [CW-1:0] FLUSH_LAST = CW'(D);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] ADDR_ONE   = AW'(1);

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        FLUSH,
        DRAIN,
        READ,
        WAIT_RD,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [AW-1:0] len;
    logic [AW-1:0] a_base;
    logic [AW-1:0] b_base;
    logic [AW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [D-1:0]  vpipe;

    logic          rd_en;
    logic          last_rd;
    logic          busy;
    logic          done;
    logic          rd_out;
    logic          valid;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;

    assign rd_en   = (state == STREAM) && !bus.i_pause;
    assign last_rd = rd_en && (idx == len - ADDR_ONE);

    assign bus.o_src_rd_en = rd_en;
    assign bus.o_a_addr    = a_base + idx;
    assign bus.o_b_addr    = b_base + idx;
    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
    assign bus.o_rd_output = rd_out;
    assign bus.o_ain_valid = valid;
    assign bus.o_bin_valid = valid;
    assign bus.o_ain_data  = a_out;
    assign bus.o_bin_data  = b_out;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_nx = (bus.i_len == '0) ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (last_rd) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt == FLUSH_LAST) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nx = READ;
                end
            end
            READ: begin
                state_nx = WAIT_RD;
            end
            WAIT_RD: begin
                if (bus.i_rd_return) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // cnt measures time spent in the current state; restarts on every transition
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            cnt <= '0;
        end else if (state_nx != state) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            len    <= '0;
            a_base <= '0;
            b_base <= '0;
            idx    <= '0;
        end else if (state == IDLE && bus.i_start) begin
            len    <= bus.i_len;
            a_base <= bus.i_a_base;
            b_base <= bus.i_b_base;
            idx    <= '0;
        end else if (rd_en) begin
            idx <= idx + ADDR_ONE;
        end
    end

    // Valid pipe mirrors the RAM read latency so data and valid line up
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            vpipe <= '0;
            valid <= 1'b0;
            a_out <= '0;
            b_out <= '0;
        end else begin
            vpipe[0] <= rd_en;
            for (int i = 1; i < D; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
            valid <= vpipe[D-1];
            if (vpipe[D-1]) begin
                a_out <= bus.i_a_data;
                b_out <= bus.i_b_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            rd_out <= 1'b0;
        end else begin
            busy   <= (state_nx != IDLE);
            done   <= (state_nx == DONE);
            rd_out <= (state_nx == READ);
        end
    end
endmodule
